// File: rtl/crossbar_sched_pkg.sv
// crossbar_sched_pkg
// Shared definitions for the 2x2 crossbar scheduler: per-source FSM state
// encoding, crossbar select values and sink indices.
// Optional build macro used by the scheduler files: CROSSBAR_SCHED_TIMEOUT_EN.
package crossbar_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } port_state_t;

  // Crossbar select: straight routes in1->out1/in2->out2, cross swaps them.
  localparam logic SEL_STRAIGHT = 1'b0;
  localparam logic SEL_CROSS    = 1'b1;

  // Sink indices as carried on the dst request bits.
  localparam logic SINK_OUT1 = 1'b0;
  localparam logic SINK_OUT2 = 1'b1;

endpackage

// File: rtl/crossbar_sched_port.sv
// crossbar_sched_port
// Per-source request FSM (IDLE -> WAIT -> GRANT -> IDLE), destination hold,
// and, when CROSSBAR_SCHED_TIMEOUT_EN is defined, the grant hold counter and
// timeout error pulse.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   req, dst_in      : source request level and requested sink
//   done             : last-cycle strobe, honoured only in GRANT
//   win              : arbitration result from the top, valid while want is high
//   want             : source is waiting with its request still asserted
//   dst              : sink of interest (live request in WAIT, latched in GRANT)
//   gnt              : grant level
//   rel              : grant ends at the coming edge (done or timeout)
//   err              : registered one-cycle timeout pulse (0 when timeout disabled)
module crossbar_sched_port
  import crossbar_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic dst_in,
  input  logic done,
  input  logic win,
  output logic want,
  output logic dst,
  output logic gnt,
  output logic rel,
  output logic err
);

  port_state_t state;
  port_state_t state_next;
  logic        dst_hold;
  logic        timeout;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the requested sink on the grant edge so it stays fixed for the transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_hold <= 1'b0;
    end else if ((state == ST_WAIT) && win) begin
      dst_hold <= dst_in;
    end
  end

`ifdef CROSSBAR_SCHED_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             err_r;

  // Counts cycles spent in GRANT; reads 1 during the first grant cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state_next == ST_GRANT) begin
      hold_cnt <= hold_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      hold_cnt <= '0;
    end
  end

  // A done on the final cycle takes priority, so no error in that case.
  assign timeout = (state == ST_GRANT) && !done &&
                   (hold_cnt == CNT_W'(MAX_HOLD));

  // Error pulse lines up with gnt falling after a forced release.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout;
    end
  end

  assign err = err_r;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Next-state logic; req is ignored while granted.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (req) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!req)     state_next = ST_IDLE;
        else if (win) state_next = ST_GRANT;
      end
      ST_GRANT: if (done || timeout) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    want = (state == ST_WAIT) && req;
    gnt  = (state == ST_GRANT);
    dst  = gnt ? dst_hold : dst_in;
    rel  = gnt && (done || timeout);
  end

endmodule

// File: rtl/crossbar_scheduler.sv
// crossbar_scheduler
// Arbitration/sequencing controller for a 2x2 crossbar. Grants compatible
// requests concurrently, round-robins same-sink conflicts and holds the
// crossbar select stable while any grant is active.
// Optional feature: define CROSSBAR_SCHED_TIMEOUT_EN to force-release grants
// held for MAX_HOLD cycles and pulse err1/err2.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   req1, req2       : source requests (level)
//   dst1, dst2       : requested sink, 0 = out1, 1 = out2
//   done1, done2     : last-cycle strobes
//   gnt1, gnt2       : grant levels
//   select           : crossbar select, 0 = straight, 1 = crossed
//   busy1, busy2     : out1/out2 occupied
//   err1, err2       : one-cycle timeout pulses
module crossbar_scheduler
  import crossbar_sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic req1,
  input  logic req2,
  input  logic dst1,
  input  logic dst2,
  input  logic done1,
  input  logic done2,
  output logic gnt1,
  output logic gnt2,
  output logic select,
  output logic busy1,
  output logic busy2,
  output logic err1,
  output logic err2
);

  logic       want1, want2;
  logic       pdst1, pdst2;
  logic       win1, win2;
  logic       rel1, rel2;
  logic [1:0] busy_r;
  logic [1:0] rel_r;       // sink released on the previous edge
  logic       ptr_r;       // 0 = source 1 wins the next conflict
  logic       select_r;
  logic [1:0] free;
  logic [1:0] rel_now;
  logic [1:0] busy_next;
  logic       ptr_next;
  logic       select_next;

  crossbar_sched_port #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_port1 (
    .clk(clk), .rst(rst), .req(req1), .dst_in(dst1), .done(done1), .win(win1),
    .want(want1), .dst(pdst1), .gnt(gnt1), .rel(rel1), .err(err1)
  );

  crossbar_sched_port #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_port2 (
    .clk(clk), .rst(rst), .req(req2), .dst_in(dst2), .done(done2), .win(win2),
    .want(want2), .dst(pdst2), .gnt(gnt2), .rel(rel2), .err(err2)
  );

  // Arbitration and next values for busy, pointer and select. A sink held by
  // one source leaves only the other sink, which always matches the current
  // select, so select only moves when no grant is active.
  always_comb begin
    free        = ~busy_r & ~rel_r;
    win1        = 1'b0;
    win2        = 1'b0;
    ptr_next    = ptr_r;
    select_next = select_r;
    rel_now     = 2'b00;

    if (want1 && free[pdst1] && want2 && free[pdst2] && (pdst1 == pdst2)) begin
      win1     = !ptr_r;
      win2     = ptr_r;
      ptr_next = !ptr_r;
    end else begin
      win1 = want1 && free[pdst1];
      win2 = want2 && free[pdst2];
    end

    if (win1) begin
      select_next = pdst1;
    end else if (win2) begin
      select_next = pdst2 ? SEL_STRAIGHT : SEL_CROSS;
    end else begin
      select_next = select_r;
    end

    if (rel1) rel_now[pdst1] = 1'b1;
    if (rel2) rel_now[pdst2] = 1'b1;

    busy_next = busy_r & ~rel_now;
    if (win1) busy_next[pdst1] = 1'b1;
    if (win2) busy_next[pdst2] = 1'b1;
  end

  // Sink occupancy, release bubble, round-robin pointer and select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 2'b00;
      rel_r    <= 2'b00;
      ptr_r    <= 1'b0;
      select_r <= SEL_STRAIGHT;
    end else begin
      busy_r   <= busy_next;
      rel_r    <= rel_now;
      ptr_r    <= ptr_next;
      select_r <= select_next;
    end
  end

  assign busy1  = busy_r[SINK_OUT1];
  assign busy2  = busy_r[SINK_OUT2];
  assign select = select_r;

endmodule

// File: tb/tb_crossbar_scheduler.sv
// Directed self-checking bench for crossbar_scheduler. Observed outputs are
// packed as {gnt1, gnt2, select, busy1, busy2, err1, err2}.
module tb_crossbar_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req1 = 1'b0, req2 = 1'b0;
  logic dst1 = 1'b0, dst2 = 1'b0;
  logic done1 = 1'b0, done2 = 1'b0;
  logic gnt1, gnt2, select, busy1, busy2, err1, err2;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] exp_v;

  crossbar_scheduler #(.MAX_HOLD(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .dst1(dst1), .dst2(dst2),
    .done1(done1), .done2(done2), .gnt1(gnt1), .gnt2(gnt2), .select(select),
    .busy1(busy1), .busy2(busy2), .err1(err1), .err2(err2)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {gnt1, gnt2, select, busy1, busy2, err1, err2};
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; done1 = 1'b0; done2 = 1'b0;
    dst1 = 1'b0; dst2 = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL reset_values: got %b expected %b", outs(), exp_v); end
  endtask

  task automatic test_single_grant();
    do_reset();
    req1 = 1'b1; dst1 = 1'b0;
    step(1);
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL single_wait: got %b expected %b", outs(), exp_v); end
    step(1);
    exp_v = 7'b1001000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL single_grant: got %b expected %b", outs(), exp_v); end
    done1 = 1'b1; req1 = 1'b0;
    step(1);
    done1 = 1'b0;
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL single_release: got %b expected %b", outs(), exp_v); end
  endtask

  task automatic test_concurrent();
    do_reset();
    req1 = 1'b1; dst1 = 1'b1; req2 = 1'b1; dst2 = 1'b0;
    step(2);
    exp_v = 7'b1111100; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL concurrent_grant: got %b expected %b", outs(), exp_v); end
    req1 = 1'b0; req2 = 1'b0; done1 = 1'b1; done2 = 1'b1;
    step(1);
    done1 = 1'b0; done2 = 1'b0;
    exp_v = 7'b0010000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL concurrent_release: got %b expected %b", outs(), exp_v); end
  endtask

  task automatic test_conflict_rr();
    do_reset();
    req1 = 1'b1; req2 = 1'b1; dst1 = 1'b0; dst2 = 1'b0;
    step(2);
    exp_v = 7'b1001000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_first_src1: got %b expected %b", outs(), exp_v); end
    req1 = 1'b0; done1 = 1'b1;
    step(1);
    done1 = 1'b0;
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_release1: got %b expected %b", outs(), exp_v); end
    step(1);
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_bubble: got %b expected %b", outs(), exp_v); end
    step(1);
    exp_v = 7'b0111000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_src2_after: got %b expected %b", outs(), exp_v); end
    req2 = 1'b0; done2 = 1'b1;
    step(1);
    done2 = 1'b0;
    req1 = 1'b1; req2 = 1'b1;
    step(2);
    exp_v = 7'b0111000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_pointer_flip: got %b expected %b", outs(), exp_v); end
    req1 = 1'b0; req2 = 1'b0; done2 = 1'b1;
    step(1);
    done2 = 1'b0;
    exp_v = 7'b0010000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL conflict_final_release: got %b expected %b", outs(), exp_v); end
  endtask

  task automatic test_held_sink();
    do_reset();
    req2 = 1'b1; dst2 = 1'b0;
    step(2);
    exp_v = 7'b0111000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL held_src2_grant: got %b expected %b", outs(), exp_v); end
    req1 = 1'b1; dst1 = 1'b0;
    step(3);
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL held_src1_waits: got %b expected %b", outs(), exp_v); end
    dst1 = 1'b1;
    step(1);
    exp_v = 7'b1111100; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL held_dst_change_grant: got %b expected %b", outs(), exp_v); end
    req1 = 1'b0; req2 = 1'b0; done1 = 1'b1; done2 = 1'b1;
    step(1);
    done1 = 1'b0; done2 = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    req1 = 1'b1; dst1 = 1'b0;
    step(2);
    req1 = 1'b0;
    exp_v = 7'b1001000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL hold_grant_start: got %b expected %b", outs(), exp_v); end
`ifdef CROSSBAR_SCHED_TIMEOUT_EN
    step(3);
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_cycle4: got %b expected %b", outs(), exp_v); end
    step(1);
    exp_v = 7'b0000010; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_release: got %b expected %b", outs(), exp_v); end
    step(1);
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_err_one_cycle: got %b expected %b", outs(), exp_v); end
    req1 = 1'b1;
    step(2);
    req1 = 1'b0;
    step(3);
    done1 = 1'b1;
    step(1);
    done1 = 1'b0;
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL timeout_done_wins: got %b expected %b", outs(), exp_v); end
`else
    step(20);
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL hold_no_timeout: got %b expected %b", outs(), exp_v); end
    done1 = 1'b1;
    step(1);
    done1 = 1'b0;
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL hold_done_release: got %b expected %b", outs(), exp_v); end
`endif
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req1 = 1'b1; dst1 = 1'b0;
    step(2);
    req2 = 1'b1; dst2 = 1'b0;
    step(1);
    exp_v = 7'b1001000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL midrst_before: got %b expected %b", outs(), exp_v); end
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0;
    step(1);
    rst = 1'b0;
    exp_v = 7'b0000000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL midrst_cleared: got %b expected %b", outs(), exp_v); end
    step(3);
    n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL midrst_no_stale_grant: got %b expected %b", outs(), exp_v); end
    req2 = 1'b1;
    step(2);
    exp_v = 7'b0111000; n_vec++;
    if (outs() !== exp_v) begin n_err++; $display("FAIL midrst_reassert: got %b expected %b", outs(), exp_v); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_concurrent();
    test_conflict_rr();
    test_held_sink();
    test_timeout();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crossbar_scheduler.md
# crossbar_scheduler

Sequencing/arbitration controller for the 2x2 crossbar datapath (sources in1/in2, sinks out1/out2, select 0 = straight, 1 = crossed). Each source requests a destination sink and holds it for a multi-cycle transfer ended by a done strobe. The block grants compatible requests concurrently and round-robins conflicting ones. It drives the crossbar `select` and keeps it stable for the life of every active grant.

## Interface
- `MAX_HOLD`, 16: max grant length in cycles before forced release (timeout build only); ≥2.
- `CNT_W`, 5: hold-counter width; must hold `MAX_HOLD`.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req1`, `req2` in 1: source requests; level, held until grant or withdrawn.
- `dst1`, `dst2` in 1: requested sink (0 = out1, 1 = out2); sampled while the request waits.
- `done1`, `done2` in 1: last-cycle strobe; honoured only while the matching `gnt` is high.
- `gnt1`, `gnt2` out 1: grant level, registered.
- `select` out 1: crossbar select, registered.
- `busy1`, `busy2` out 1: out1/out2 occupied.
- `err1`, `err2` out 1: one-cycle timeout pulse.

## Operation
- Per-source FSM: IDLE → WAIT (req high) → GRANT (sink free and won) → IDLE (done, timeout, or reset). WAIT → IDLE if req drops before grant; no grant issued.
- A sink is free if not busy and not released this cycle (one bubble after release).
- Grant sets `select` = dst1 if source 1 is granted, else !dst2. With one grant already active, any free sink is consistent with the current `select`, so `select` never changes while any `gnt` is high.
- Both waiting, different dsts, both free: both granted on the same edge. `select` = dst1.
- Both waiting, same dst, sink free: the round-robin pointer wins. After the grant the pointer flips to the loser. The pointer moves only on a conflict.
- Request for a sink held by the other source: stays in WAIT.
- dst change during WAIT: the current value is used at the next evaluation.
- done with gnt high: at that edge gnt and the busy bit clear. A new req at the same edge re-enters WAIT.
- `req` during GRANT is ignored. A new request needs IDLE first (req may stay high; it re-enters WAIT the cycle after release).
- Idle: `select` holds its last value.

## Timing
- Reset values: gnt1 = gnt2 = 0, select = 0, busy1 = busy2 = 0, err1 = err2 = 0, pointer = source 1, FSMs IDLE, counters 0.
- Grant latency: req high at edge N → WAIT; gnt high after edge N+1 at earliest.
- `select` and `busy` update on the same edge as `gnt`.
- Release: done sampled at edge M → gnt/busy low after M. The freed sink can be granted at edge M+2 at earliest.
- Reset mid-transfer: all grants drop on the next edge. Pending requests are discarded.

## Configuration
- `CROSSBAR_SCHED_TIMEOUT_EN` defined:
  - Each source counts cycles in GRANT (1 on the grant cycle).
  - With no done by count == MAX_HOLD, the grant is force-released at that edge.
  - `errN` pulses high one cycle, coincident with gnt falling.
  - done and timeout on the same edge: treated as done; no err.
- Undefined: no counters. Grants last until done or reset. err1/err2 stay present, tied 0.

## Structure
- `crossbar_sched_pkg`: FSM state encodings (IDLE, WAIT, GRANT), SEL_STRAIGHT = 0, SEL_CROSS = 1, sink indices.
- Sub-module `crossbar_sched_port`, instantiated twice:
  - Contents: per-source FSM, hold counter and err logic.
  - Inputs: req, dst, done, win.
  - Outputs: want, dst, gnt, release.
- Top holds: sink-free logic, round-robin pointer, `select` register, busy registers.

## Test plan
- Reset, then req1 = 1, dst1 = 0 → gnt1 = 1, select = 0, busy1 = 1 two edges after req. done1 pulse → gnt1 = 0, busy1 = 0 next edge.
- req1/dst1 = 1 and req2/dst2 = 0 raised together → gnt1 = gnt2 = 1 on the same edge, select = 1, busy1 = busy2 = 1.
- Both request dst = 0 from reset → gnt1 first; after done1, gnt2 with a one-cycle bubble, select = 1. Repeat the conflict → source 2 wins this time (pointer flip).
- Source 2 holds out1 (select = 1); req1 with dst1 = 0 stays WAIT. req1 with dst1 = 1 granted, select stays 1.
- Timeout build, MAX_HOLD = 4, gnt1 with no done → gnt1 falls and err1 pulses after 4 cycles of grant. Done on cycle 4 → no err.
- rst asserted mid-grant with the other source waiting → all outputs return to reset values next edge. No grant appears until req re-asserts.
